// File: rtl/ring_buffer_pkg.sv
// Shared definitions for the multi-channel ring buffer.
// Contents: default parameter values, a width helper that never returns 0,
// and the packed record that holds the read-side grant lock.
package ring_buffer_pkg;

  localparam int unsigned DefDataSize   = 32;
  localparam int unsigned DefBufferSize = 8;
  localparam int unsigned DefChannels   = 4;

  // Storage width for a locked channel index; wide enough for any sane CHANNELS.
  localparam int unsigned MaxChW = 8;

  // max(1, $clog2(n)) so that single-bit selects stay legal for tiny sizes.
  function automatic int unsigned width_of(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  // Read-side lock: once a word is shown and not taken, the channel is pinned.
  typedef struct packed {
    logic              locked;
    logic [MaxChW-1:0] ch;
  } lock_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request searching cyclically from last_grant_i + 1.
// Ports:
//   req_i        per-channel request (channel non-empty)
//   last_grant_i channel granted by the previous pop
//   grant_oh_o   one-hot grant (all zero when no request)
//   grant_o      encoded grant (0 when no request)
//   valid_o      at least one request present
module rr_arbiter
  import ring_buffer_pkg::*;
#(
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned CH_W     = width_of(DefChannels)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [CH_W-1:0]     last_grant_i,
  output logic [CHANNELS-1:0] grant_oh_o,
  output logic [CH_W-1:0]     grant_o,
  output logic                valid_o
);

  int unsigned idx;

  always_comb begin
    grant_oh_o = '0;
    grant_o    = '0;
    valid_o    = 1'b0;
    idx        = 0;
    // Offsets 1..CHANNELS so the last winner is considered last.
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = (32'(last_grant_i) + i) % CHANNELS;
      if (!valid_o && req_i[idx]) begin
        valid_o         = 1'b1;
        grant_o         = CH_W'(idx);
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_buffer_vc.sv
// Multi-channel ring buffer: CHANNELS independent FIFOs behind one write port
// and one round-robin read port. Depth need not be a power of two.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   buf_rst_i         synchronous per-channel flush
//   rx_i/rx_ch_i      write request and its target channel
//   rx_ack_o          target channel not full
//   data_i            write data
//   tx_o/tx_ch_o      word available and its channel
//   tx_ack_i          consumer takes the presented word
//   data_o            head word of the granted channel
//   used_o            per-channel occupancy, channel c at [c*CNT_W +: CNT_W]
module ring_buffer_vc
  import ring_buffer_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DefDataSize,
  parameter int unsigned BUFFER_SIZE = DefBufferSize,
  parameter int unsigned CHANNELS    = DefChannels,
  localparam int unsigned CH_W       = width_of(CHANNELS),
  localparam int unsigned PTR_W      = width_of(BUFFER_SIZE),
  localparam int unsigned CNT_W      = width_of(BUFFER_SIZE + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       buf_rst_i,
  input  logic                      rx_i,
  input  logic [CH_W-1:0]           rx_ch_i,
  output logic                      rx_ack_o,
  input  logic [DATA_SIZE-1:0]      data_i,
  output logic                      tx_o,
  output logic [CH_W-1:0]           tx_ch_o,
  input  logic                      tx_ack_i,
  output logic [DATA_SIZE-1:0]      data_o,
  output logic [CHANNELS*CNT_W-1:0] used_o
);

  logic [DATA_SIZE-1:0] mem_q  [CHANNELS][BUFFER_SIZE];
  logic [PTR_W-1:0]     head_q [CHANNELS];
  logic [PTR_W-1:0]     head_d [CHANNELS];
  logic [PTR_W-1:0]     tail_q [CHANNELS];
  logic [PTR_W-1:0]     tail_d [CHANNELS];
  logic [CNT_W-1:0]     cnt_q  [CHANNELS];
  logic [CNT_W-1:0]     cnt_d  [CHANNELS];
  logic [CH_W-1:0]      last_grant_q, last_grant_d;
  lock_t                lock_q, lock_d;

  logic [CHANNELS-1:0] nonempty, arb_oh, lock_oh, wr_oh, rd_oh;
  logic [CH_W-1:0]     arb_grant, grant;
  logic                arb_valid, accept, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    nonempty = '0;
    used_o   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      nonempty[c]                = (cnt_q[c] != '0);
      used_o[c*CNT_W +: CNT_W]   = cnt_q[c];
    end
  end

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .CH_W    (CH_W)
  ) u_arb (
    .req_i       (nonempty),
    .last_grant_i(last_grant_q),
    .grant_oh_o  (arb_oh),
    .grant_o     (arb_grant),
    .valid_o     (arb_valid)
  );

  // A locked channel is always non-empty: only a pop or a flush can drain it,
  // and both clear the lock.
  assign grant    = lock_q.locked ? CH_W'(lock_q.ch) : arb_grant;
  assign tx_o     = arb_valid | lock_q.locked;
  assign tx_ch_o  = grant;
  assign data_o   = mem_q[grant][tail_q[grant]];
  // Depends only on stored count, so a same-cycle pop never frees a full slot.
  assign rx_ack_o = (cnt_q[rx_ch_i] != CNT_W'(BUFFER_SIZE));
  assign accept   = rx_i & rx_ack_o;
  assign pop      = tx_o & tx_ack_i;

  always_comb begin
    lock_oh = '0;
    wr_oh   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      lock_oh[c] = (CH_W'(lock_q.ch) == CH_W'(c));
      wr_oh[c]   = accept && (rx_ch_i == CH_W'(c));
    end
    rd_oh = pop ? (lock_q.locked ? lock_oh : arb_oh) : '0;
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      head_d[c] = head_q[c];
      tail_d[c] = tail_q[c];
      cnt_d[c]  = cnt_q[c];
      if (buf_rst_i[c]) begin
        // Flush wins over a same-cycle write; a same-cycle pop still completes.
        head_d[c] = '0;
        tail_d[c] = '0;
        cnt_d[c]  = '0;
      end else begin
        if (wr_oh[c]) head_d[c] = next_ptr(head_q[c]);
        if (rd_oh[c]) tail_d[c] = next_ptr(tail_q[c]);
        if (wr_oh[c] && !rd_oh[c]) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end else if (!wr_oh[c] && rd_oh[c]) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    if (pop) begin
      lock_d       = '0;
      last_grant_d = grant;
    end else if (tx_o) begin
      lock_d.locked = 1'b1;
      lock_d.ch     = MaxChW'(grant);
    end
    // Flushing the shown channel drops the pin; last_grant is left alone.
    if (buf_rst_i[grant]) lock_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      last_grant_q <= CH_W'(CHANNELS - 1);
      lock_q       <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        head_q[c] <= head_d[c];
        tail_q[c] <= tail_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (accept) mem_q[rx_ch_i][head_q[rx_ch_i]] <= data_i;
  end

endmodule

// File: tb/tb_ring_buffer_vc.sv
// Self-checking bench for ring_buffer_vc: instance A (depth 8) covers reset,
// fill/full, round-robin order, lock stability and flush; instance B (depth 6)
// streams 20 words through one channel with random handshakes.
module tb_ring_buffer_vc;

  localparam int CH   = 4;
  localparam int CHW  = 2;
  localparam int DW   = 32;
  localparam int BA   = 8;
  localparam int CNTA = 4;
  localparam int BB   = 6;
  localparam int CNTB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0]      a_buf_rst, b_buf_rst;
  logic               a_rx, b_rx, a_rx_ack, b_rx_ack;
  logic [CHW-1:0]     a_rx_ch, b_rx_ch, a_tx_ch, b_tx_ch;
  logic [DW-1:0]      a_din, b_din, a_dout, b_dout;
  logic               a_tx, b_tx, a_tx_ack, b_tx_ack;
  logic [CH*CNTA-1:0] a_used;
  logic [CH*CNTB-1:0] b_used;

  ring_buffer_vc #(.DATA_SIZE(DW), .BUFFER_SIZE(BA), .CHANNELS(CH)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .buf_rst_i(a_buf_rst), .rx_i(a_rx), .rx_ch_i(a_rx_ch),
    .rx_ack_o(a_rx_ack), .data_i(a_din), .tx_o(a_tx), .tx_ch_o(a_tx_ch),
    .tx_ack_i(a_tx_ack), .data_o(a_dout), .used_o(a_used)
  );

  ring_buffer_vc #(.DATA_SIZE(DW), .BUFFER_SIZE(BB), .CHANNELS(CH)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .buf_rst_i(b_buf_rst), .rx_i(b_rx), .rx_ch_i(b_rx_ch),
    .rx_ack_o(b_rx_ack), .data_i(b_din), .tx_o(b_tx), .tx_ch_o(b_tx_ch),
    .tx_ack_i(b_tx_ack), .data_o(b_dout), .used_o(b_used)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state for A: per-channel data queues, counts, optional channel order.
  logic [DW-1:0] qa [CH][$];
  int            mcnt [CH];
  int            cha_exp [$];
  // Scoreboard state for B (channel 0 only).
  int bcnt, bexp, bnext;

  logic any_a;
  int   mon_ch;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: checks tx_o against the model and every popped word.
  always @(negedge clk) begin
    if (!rst) begin
      any_a = 1'b0;
      for (int c = 0; c < CH; c++) if (mcnt[c] != 0) any_a = 1'b1;
      check("a_tx_o", a_tx, any_a);
      if (a_tx && a_tx_ack) begin
        mon_ch = int'(a_tx_ch);
        if (cha_exp.size() != 0) check("a_tx_ch_order", a_tx_ch, cha_exp.pop_front());
        check("a_pop_nonempty", qa[mon_ch].size() != 0, 1);
        if (qa[mon_ch].size() != 0) begin
          check("a_data", a_dout, qa[mon_ch].pop_front());
          mcnt[mon_ch]--;
        end
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (!rst) begin
      check("b_tx_o", b_tx, bcnt != 0);
      if (b_tx && b_tx_ack) begin
        check("b_tx_ch", b_tx_ch, 0);
        check("b_data", b_dout, bexp);
        bexp++;
        bcnt--;
      end
    end
  end

  // One clock of stimulus on A; entered and left at posedge+1.
  task automatic a_cycle(input logic rx, input int ch, input logic [DW-1:0] d,
                         input logic ack, input logic [CH-1:0] flush);
    logic acc;
    a_rx = rx; a_rx_ch = CHW'(ch); a_din = d; a_tx_ack = ack; a_buf_rst = flush;
    #1;
    check("a_rx_ack", a_rx_ack, mcnt[ch] != BA);
    for (int c = 0; c < CH; c++) check("a_used", a_used[c*CNTA +: CNTA], mcnt[c]);
    acc = rx && (mcnt[ch] != BA) && !flush[ch];
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      if (flush[c]) begin
        qa[c].delete();
        mcnt[c] = 0;
      end
    end
    if (acc) begin
      qa[ch].push_back(d);
      mcnt[ch]++;
    end
    #1;
    a_rx = 1'b0; a_tx_ack = 1'b0; a_buf_rst = '0;
  endtask

  task automatic b_cycle(input logic rx, input logic ack);
    logic acc;
    b_rx = rx; b_din = DW'(bnext); b_tx_ack = ack;
    #1;
    check("b_rx_ack", b_rx_ack, bcnt != BB);
    check("b_used", b_used[CNTB-1:0], bcnt);
    check("b_used_max", b_used[CNTB-1:0] <= CNTB'(BB), 1);
    acc = rx && (bcnt != BB);
    @(posedge clk);
    if (acc) begin
      bnext++;
      bcnt++;
    end
    #1;
    b_rx = 1'b0; b_tx_ack = 1'b0;
  endtask

  // Asserts reset and checks outputs before any clock edge, then releases.
  task automatic do_reset();
    rst = 1'b1;
    a_rx = 1'b0; a_tx_ack = 1'b0; a_buf_rst = '0;
    b_rx = 1'b0; b_tx_ack = 1'b0;
    for (int c = 0; c < CH; c++) begin
      a_rx_ch = CHW'(c);
      #1;
      check("rst_rx_ack", a_rx_ack, 1);
    end
    check("rst_tx_o", a_tx, 0);
    check("rst_tx_ch", a_tx_ch, 0);
    check("rst_used", a_used, 0);
    check("rst_b_used", b_used, 0);
    for (int c = 0; c < CH; c++) begin
      qa[c].delete();
      mcnt[c] = 0;
    end
    cha_exp.delete();
    bcnt = 0; bexp = 0; bnext = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic a_drain(input int cycles);
    for (int i = 0; i < cycles; i++) a_cycle(1'b0, 0, '0, 1'b1, '0);
  endtask

  initial begin
    a_rx_ch = '0; a_din = '0; b_rx_ch = '0; b_din = '0; b_buf_rst = '0;
    for (int c = 0; c < CH; c++) mcnt[c] = 0;
    bcnt = 0; bexp = 0; bnext = 0;
    do_reset();

    // Fill ch2, refuse the 9th write, ch0 still accepts.
    for (int i = 0; i < 8; i++) a_cycle(1'b1, 2, DW'(32'h100 + i), 1'b0, '0);
    a_cycle(1'b1, 2, 32'h108, 1'b0, '0);
    a_cycle(1'b0, 0, '0, 1'b0, '0);
    for (int i = 0; i < 8; i++) cha_exp.push_back(2);
    a_drain(10);
    check("a_ch2_drained", qa[2].size(), 0);
    check("a_order_done_t2", cha_exp.size(), 0);

    // Reset mid-traffic.
    a_cycle(1'b1, 1, 32'h55, 1'b0, '0);
    a_cycle(1'b1, 1, 32'h56, 1'b0, '0);
    do_reset();

    // Round-robin order 0,1,3,0,1,3.
    a_cycle(1'b1, 0, 32'h10, 1'b0, '0);
    a_cycle(1'b1, 0, 32'h11, 1'b0, '0);
    a_cycle(1'b1, 1, 32'h20, 1'b0, '0);
    a_cycle(1'b1, 1, 32'h21, 1'b0, '0);
    a_cycle(1'b1, 3, 32'h30, 1'b0, '0);
    a_cycle(1'b1, 3, 32'h31, 1'b0, '0);
    cha_exp = '{0, 1, 3, 0, 1, 3};
    a_drain(8);
    check("a_order_done_t3", cha_exp.size(), 0);

    // Lock stability: ch1 shown while ch0 fills behind it.
    do_reset();
    a_cycle(1'b1, 1, 32'hAA, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      check("a_hold_ch", a_tx_ch, 1);
      check("a_hold_data", a_dout, 32'hAA);
      a_cycle(1'b1, 0, DW'(32'hB0 + k), 1'b0, '0);
    end
    check("a_hold_ch_end", a_tx_ch, 1);
    check("a_hold_data_end", a_dout, 32'hAA);
    cha_exp = '{1, 0, 0, 0, 0, 0};
    a_drain(8);
    check("a_order_done_t4", cha_exp.size(), 0);

    // Flush ch3 with a colliding write; lock on ch3 must drop.
    do_reset();
    for (int i = 0; i < 5; i++) a_cycle(1'b1, 3, DW'(32'h300 + i), 1'b0, '0);
    a_cycle(1'b1, 3, 32'hDEAD, 1'b0, 4'b1000);
    a_cycle(1'b1, 1, 32'h41, 1'b0, '0);
    a_cycle(1'b1, 0, 32'h40, 1'b0, '0);
    cha_exp = '{1, 0};
    a_drain(4);
    check("a_order_done_t6", cha_exp.size(), 0);
    check("a_ch3_empty", a_used[3*CNTA +: CNTA], 0);

    // Depth-6 stream of 0..19 through ch0 of instance B.
    do_reset();
    for (int i = 0; i < BB; i++) b_cycle(1'b1, 1'b0);
    b_cycle(1'b1, 1'b1);
    check("b_full_pop_refused", b_used[CNTB-1:0], BB - 1);
    for (int i = 0; i < 60; i++) begin
      b_cycle((bnext < 20) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 40 && bexp < 20; i++) b_cycle(bnext < 20, 1'b1);
    check("b_all_out", bexp, 20);
    check("b_all_in", bnext, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ring_buffer_vc.md
Name: ring_buffer_vc

Overview:
Multi-channel ring buffer. CHANNELS independent FIFOs share one write port and one read port.
- Writer selects the target channel per word.
- Read side picks among non-empty channels by round-robin arbitration and reports the channel of the presented word.
- Depth need not be a power of 2. Per-channel occupancy and per-channel flush are provided.
- Sits between a packet source and a consumer multiplexing virtual channels, e.g. NoC ports.

Parameters:
DATA_SIZE, 32, word width in bits
BUFFER_SIZE, 8, entries per channel; any value >= 2
CHANNELS, 4, number of channels; >= 2
(derived) CH_W = $clog2(CHANNELS), PTR_W = $clog2(BUFFER_SIZE), CNT_W = $clog2(BUFFER_SIZE+1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
buf_rst_i  in  CHANNELS  synchronous per-channel flush
rx_i  in  1  write request
rx_ch_i  in  CH_W  target channel of the write
rx_ack_o  out  1  target channel can accept (not full)
data_i  in  DATA_SIZE  write data
tx_o  out  1  word available on data_o
tx_ch_o  out  CH_W  channel of the presented word
tx_ack_i  in  1  consumer takes the word
data_o  out  DATA_SIZE  head word of the granted channel
used_o  out  CHANNELS*CNT_W  occupancy per channel, channel c at [c*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_i high, asynchronous, active-high):
  - All heads, tails and counts = 0; lock = 0; last_grant = CHANNELS-1, so channel 0 wins first.
  - Outputs: tx_o=0, tx_ch_o=0, rx_ack_o=1, used_o=0. data_o is undefined. Storage is not reset.
- Write accept:
  - rx_ack_o = (count[rx_ch_i] != BUFFER_SIZE), combinational from state and rx_ch_i only.
  - Accept = rx_i && rx_ack_o. On accept: mem[rx_ch_i][head] <= data_i; head advances; count +1.
- Pointer wrap: head/tail == BUFFER_SIZE-1 -> 0 (explicit compare, no power-of-2 overflow).
- Read side:
  - tx_o = any channel non-empty, or lock held.
  - Unlocked: grant = first non-empty channel searching from last_grant+1 cyclically.
  - Locked: grant = locked channel.
  - data_o = mem[grant][tail[grant]]; tx_ch_o = grant.
  - Pop = tx_o && tx_ack_i: tail[grant] advances, count -1, last_grant <= grant, lock <= 0.
- Stability rule: tx_o high with tx_ack_i low sets lock <= 1 and stores grant. tx_ch_o and data_o must not change until the pop. Arrivals on other channels do not reorder.
- Latency: a word written at edge N is first presentable in the cycle after edge N. No write-to-read bypass.
- Full: no write accepted even if the same channel pops that cycle. There is no combinational path tx_ack_i -> rx_ack_o.
- Simultaneous write and pop on the same channel: count unchanged, both pointers advance.
- Empty channel: never granted; pop cannot occur.
- Flush buf_rst_i[c]:
  - Next edge: head/tail/count of channel c = 0.
  - Flush overrides a same-cycle write to c; that word is dropped even though rx_ack_o was high.
  - A same-cycle pop of c completes for the consumer.
  - If c is locked, the lock clears; last_grant is unchanged.
- Reset mid-operation: all state returns to reset values immediately. In-flight words are lost.
- Count width: CNT_W bits hold 0..BUFFER_SIZE inclusive.

Decomposition:
- Package ring_buffer_pkg:
  - width helper function (max(1,$clog2(n)))
  - typedef for the grant/lock record {locked, ch}
  - localparam defaults
- Sub-module rr_arbiter (CHANNELS requests, last_grant in, one-hot and encoded grant out; combinational). Lock, pointers and storage stay in ring_buffer_vc.

Test Plan:
1. Hold rst_i=1 two cycles, then release -> tx_o=0, rx_ack_o=1 on every rx_ch_i, used_o=0. Asserting rst_i mid-traffic returns the same values without waiting for a clock edge.
2. Write 0x100..0x107 to ch2 (BUFFER_SIZE=8), tx_ack_i=0 -> used_o[2] steps 1..8. rx_ack_o=0 for rx_ch_i=2 after the 8th accept, and a 9th write is not stored. rx_ack_o=1 for rx_ch_i=0.
3. Two words each into ch0, ch1, ch3, then tx_ack_i=1 continuously -> tx_ch_o sequence 0,1,3,0,1,3 with data in per-channel FIFO order, then tx_o=0.
4. ch1 holds 0xAA, tx_ack_i=0 for 5 cycles while writing ch0 -> tx_ch_o=1 and data_o=0xAA stable all 5 cycles. After the ack, ch0 is presented.
5. BUFFER_SIZE=6: stream 20 words through ch0 with random rx_i/tx_ack_i and simultaneous pop/write while full -> output order exactly 0..19. used_o[0] never exceeds 6; a write during full+pop is refused.
6. ch3 holds 5 words, pulse buf_rst_i[3] with rx_i=1, rx_ch_i=3 -> used_o[3]=0 next cycle, the written word is absent, and arbitration skips ch3.
